frag_queue_reader: RTL
======================

FRAG_QUEUE_READER -- requirements
Module: frag_queue_reader

Interface
REQ-001 SHALL have parameter QUEUE_NUM, default 32, number of fragment queues (power of 2, 2..64); QID_W = log2(QUEUE_NUM).
REQ-002 SHALL have parameter DEPTH_W, default 4, log2 of entries per queue region (1..8).
REQ-003 SHALL have parameter BUFID_W, default 9, buffer-id width.
REQ-004 SHALL have parameter RD_LAT, default 2, queue RAM read latency in cycles (1..4).
REQ-005 SHALL have parameter ARB_MODE, default 0; 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-006 SHALL have i_clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have i_rst  input  1  synchronous, active-high reset.
REQ-008 SHALL have iv_queue_empty  input  QUEUE_NUM  bit q = 1: queue q is empty.
REQ-009 SHALL have o_queue_ram_rd  output  1  one-cycle RAM read strobe.
REQ-010 SHALL have ov_queue_ram_raddr  output  QID_W+DEPTH_W  {queue id, entry index}.
REQ-011 SHALL have iv_queue_ram_rdata  input  BUFID_W+1  [BUFID_W] = last-fragment flag, [BUFID_W-1:0] = bufid.
REQ-012 SHALL have ov_bufid / o_bufid_wr  output  BUFID_W / 1  fragment bufid and one-cycle write strobe.
REQ-013 SHALL have i_pkt_last_cycle_valid  input  1  downstream finished transmitting the current fragment.
REQ-014 SHALL have ov_queue_id_free / o_queue_id_free_wr  output  QID_W / 1  queue id released and one-cycle strobe.
REQ-015 SHALL have o_frag_err  output  1  one-cycle pulse: queue region exhausted with no last flag.
REQ-016 SHALL have o_busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, READ, WAIT, GET, TRANS.
REQ-018 IDLE: if any iv_queue_empty bit is 0, SHALL select a queue per ARB_MODE, drive raddr = {qid, 0}, pulse o_queue_ram_rd, and go to WAIT; if all bits are 1, SHALL stay in IDLE with rd = 0.
REQ-019 ARB_MODE 1: search SHALL start at rr_ptr and wrap modulo QUEUE_NUM; rr_ptr SHALL become served qid+1 (mod QUEUE_NUM) only when that queue is freed.
REQ-020 WAIT: SHALL count RD_LAT-1 cycles after the rd cycle with rd = 0, then go to GET, so that rdata is sampled exactly RD_LAT cycles after the rd cycle.
REQ-021 GET: SHALL register ov_bufid = rdata[BUFID_W-1:0], pulse o_bufid_wr, latch the last flag, and go to TRANS; o_bufid_wr SHALL be visible RD_LAT+1 cycles after the o_queue_ram_rd pulse.
REQ-022 GET with last flag = 1: SHALL pulse o_queue_id_free_wr with ov_queue_id_free = current qid, in the same cycle as o_bufid_wr.
REQ-023 GET with last flag = 0 and entry index = 2^DEPTH_W-1: SHALL still emit the bufid, pulse o_frag_err and o_queue_id_free_wr for the qid, and treat the packet as ended (no index wrap-around).
REQ-024 TRANS: SHALL drive bufid/free strobes and values to 0 and wait for i_pkt_last_cycle_valid; on it, SHALL go to IDLE if the packet ended, else to READ.
REQ-025 READ: SHALL increment the entry index by 1 (qid unchanged), pulse rd, and go to WAIT.
REQ-026 i_pkt_last_cycle_valid SHALL be ignored outside TRANS; iv_queue_empty SHALL be ignored outside IDLE.
REQ-027 A queue freed in cycle t SHALL be eligible again in IDLE from cycle t+2 onward, provided its empty bit is 0.
REQ-028 All strobes SHALL be single-cycle, and at most one RAM read SHALL be outstanding.

Reset
REQ-029 While i_rst = 1 on a clock edge: state = IDLE, rr_ptr = 0, all outputs = 0, WAIT counter = 0; asserting reset in any state SHALL abort the packet with no free strobe.

Verification
REQ-030 Defaults; empty = 0xFFFFFFFB, q2 entry0 = {1, 9'h05} -> rd with raddr = 0x020; bufid_wr with bufid = 0x05 and free_wr with qid = 2 three cycles later; return to IDLE after last_cycle_valid.
REQ-031 q5 holds 3 fragments (0x10, 0x11, last 0x12) -> raddrs 0x050, 0x051, 0x052; three bufid_wr pulses, each read issued only after last_cycle_valid; one free_wr (qid = 5) with the third.
REQ-032 ARB_MODE = 1, queues 1 and 3 non-empty with single-fragment packets, repeated -> service order 1, 3, 1, 3; ARB_MODE = 0 -> 1, 1, 1.
REQ-033 DEPTH_W = 2, q0 has 4 entries, none flagged last -> fourth bufid_wr coincides with o_frag_err and free_wr with qid = 0; no raddr 0x004 issued.
REQ-034 RD_LAT = 4 -> bufid_wr five cycles after rd; rdata changing before the sample point is not captured.
REQ-035 i_rst asserted while in TRANS -> next cycle all outputs 0 and state IDLE; no free_wr emitted.

Source files
------------

// File: rtl/frag_queue_reader.sv
// frag_queue_reader: walks a queue's RAM region one fragment at a time and hands each bufid downstream
module frag_queue_reader #(
  parameter int QUEUE_NUM = 32,
  parameter int DEPTH_W = 4,
  parameter int BUFID_W = 9,
  parameter int RD_LAT = 2,
  parameter int ARB_MODE = 0,
  localparam int QID_W = $clog2(QUEUE_NUM)
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [QUEUE_NUM-1:0]     iv_queue_empty,
  output logic                     o_queue_ram_rd,
  output logic [QID_W+DEPTH_W-1:0] ov_queue_ram_raddr,
  input  logic [BUFID_W:0]         iv_queue_ram_rdata,
  output logic [BUFID_W-1:0]       ov_bufid,
  output logic                     o_bufid_wr,
  input  logic                     i_pkt_last_cycle_valid,
  output logic [QID_W-1:0]         ov_queue_id_free,
  output logic                     o_queue_id_free_wr,
  output logic                     o_frag_err,
  output logic                     o_busy
);
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_GET, S_TRANS} state_t;
  state_t state, state_n;
  logic [QID_W-1:0] qid, qid_n, rr_ptr, rr_ptr_n, sel, base, free_n;
  logic [DEPTH_W-1:0] idx, idx_n;
  logic [1:0] cnt, cnt_n;
  logic ended, ended_n, any, last, lat_done;
  logic rd_n, bufid_wr_n, free_wr_n, err_n;
  logic [BUFID_W-1:0] bufid_n;
  logic [QID_W+DEPTH_W-1:0] raddr_n;
  assign any = ~&iv_queue_empty;
  assign last = iv_queue_ram_rdata[BUFID_W] | &idx;
  assign lat_done = cnt == 2'(RD_LAT - 1);
  assign o_busy = state != S_IDLE;
  // descending scan so the smallest offset from base wins
  always_comb begin
    base = ARB_MODE == 1 ? rr_ptr : '0;
    sel = '0;
    for (int i = QUEUE_NUM - 1; i >= 0; i--)
      if (!iv_queue_empty[base + QID_W'(i)]) sel = base + QID_W'(i);
  end
  always_comb begin
    state_n = state;
    qid_n = qid;
    idx_n = idx;
    cnt_n = cnt;
    ended_n = ended;
    rr_ptr_n = rr_ptr;
    rd_n = 1'b0;
    bufid_n = '0;
    bufid_wr_n = 1'b0;
    free_n = '0;
    free_wr_n = 1'b0;
    err_n = 1'b0;
    case (state)
      S_IDLE: if (any) begin
        qid_n = sel;
        idx_n = '0;
        rd_n = 1'b1;
        state_n = S_WAIT;
      end
      S_READ: begin
        idx_n = idx + DEPTH_W'(1);
        rd_n = 1'b1;
        state_n = S_WAIT;
      end
      S_WAIT: begin
        cnt_n = lat_done ? '0 : cnt + 2'd1;
        state_n = lat_done ? S_GET : S_WAIT;
      end
      S_GET: begin
        bufid_n = iv_queue_ram_rdata[BUFID_W-1:0];
        bufid_wr_n = 1'b1;
        ended_n = last;
        free_wr_n = last;
        free_n = last ? qid : '0;
        err_n = !iv_queue_ram_rdata[BUFID_W] && &idx;
        rr_ptr_n = last ? qid + QID_W'(1) : rr_ptr;
        state_n = S_TRANS;
      end
      S_TRANS: if (i_pkt_last_cycle_valid) state_n = ended ? S_IDLE : S_READ;
      default: state_n = S_IDLE;
    endcase
    raddr_n = rd_n ? {qid_n, idx_n} : '0;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      qid <= '0;
      idx <= '0;
      cnt <= '0;
      ended <= 1'b0;
      rr_ptr <= '0;
      o_queue_ram_rd <= 1'b0;
      ov_queue_ram_raddr <= '0;
      ov_bufid <= '0;
      o_bufid_wr <= 1'b0;
      ov_queue_id_free <= '0;
      o_queue_id_free_wr <= 1'b0;
      o_frag_err <= 1'b0;
    end else begin
      state <= state_n;
      qid <= qid_n;
      idx <= idx_n;
      cnt <= cnt_n;
      ended <= ended_n;
      rr_ptr <= rr_ptr_n;
      o_queue_ram_rd <= rd_n;
      ov_queue_ram_raddr <= raddr_n;
      ov_bufid <= bufid_n;
      o_bufid_wr <= bufid_wr_n;
      ov_queue_id_free <= free_n;
      o_queue_id_free_wr <= free_wr_n;
      o_frag_err <= err_n;
    end
  end
endmodule
